func_sel_seq: RTL and testbench

FUNC_SEL_SEQ -- requirements
Module: func_sel_seq

---
 rtl/func_sel_seq_pkg.sv | 19 +
 rtl/func_sel_seq.sv | 123 ++++++++++++
 tb/tb_func_sel_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/func_sel_seq_pkg.sv
// Shared encodings for func_sel_seq: instruction class select and FSM states.
package func_sel_seq_pkg;

    // Instruction class carried on sel
    typedef enum logic [1:0] {
        SEL_CALCU = 2'b00,
        SEL_LOAD  = 2'b01,
        SEL_SAVE  = 2'b10,
        SEL_BEQ   = 2'b11
    } sel_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_VALID = 2'b10
    } state_e;

endpackage

// File: rtl/func_sel_seq.sv
// func_sel_seq: maps an instruction class + raw function field onto an ALU
// function code, holds it behind a valid/ready handshake, and stretches the
// configured multiply code over MC_CYCLES cycles.
// Optional feature: define FUNC_SEL_PERF_EN to build the saturating BUSY
// cycle counter on perf_stall; otherwise perf_stall is tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no op held, ready to accept
// ST_BUSY  | multi-cycle op counting down, output not yet valid
// ST_VALID | out_func presented, waiting for out_ready
module func_sel_seq
    import func_sel_seq_pkg::*;
#(
    parameter int FUNC_W    = 11,
    parameter int FUNC_ADD  = 0,
    parameter int FUNC_SUB  = 1,
    parameter int FUNC_MUL  = 24,
    parameter int MC_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        sel,
    input  logic [FUNC_W-1:0] func,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FUNC_W-1:0] out_func,
    output logic              busy,
    output logic [15:0]       perf_stall
);

    localparam int CNT_W = $clog2(MC_CYCLES + 1);

    state_e              state_q, state_d;
    logic [FUNC_W-1:0]   out_func_q, out_func_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                accept;
    logic                is_mc;

    function automatic logic [FUNC_W-1:0] map_func(input logic [1:0] s,
                                                   input logic [FUNC_W-1:0] f);
        logic [FUNC_W-1:0] r;
        case (s)
            SEL_CALCU:          r = f;
            SEL_LOAD, SEL_SAVE: r = FUNC_W'(FUNC_ADD);
            default:            r = FUNC_W'(FUNC_SUB);
        endcase
        return r;
    endfunction

    // Handshake: ready when empty, or when the held result leaves this cycle
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_VALID) && out_ready);
    assign accept   = in_valid && in_ready;
    // A latency of one cycle degenerates to the ordinary path
    assign is_mc    = (sel == SEL_CALCU) && (func == FUNC_W'(FUNC_MUL)) && (MC_CYCLES > 1);

    assign out_valid = (state_q == ST_VALID);
    assign busy      = (state_q == ST_BUSY);
    assign out_func  = out_func_q;

    // Next-state, countdown and captured code
    always_comb begin
        state_d    = state_q;
        out_func_d = out_func_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: ;
            ST_BUSY: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_VALID;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_VALID: if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // Accept only happens in IDLE or in a draining VALID, so it overrides
        if (accept) begin
            out_func_d = map_func(sel, func);
            if (is_mc) begin
                state_d = ST_BUSY;
                cnt_d   = CNT_W'(MC_CYCLES - 1);
            end else begin
                state_d = ST_VALID;
            end
        end
    end

    // State, countdown and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            out_func_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            out_func_q <= out_func_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef FUNC_SEL_PERF_EN
    logic [15:0] perf_q;

    // Saturating count of cycles spent in BUSY; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if ((state_q == ST_BUSY) && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_stall = perf_q;
`else
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_func_sel_seq.sv
// Testbench for func_sel_seq: scoreboard of expected codes, cycle-level
// reference model of handshake/latency, directed scenarios then random traffic.
`timescale 1ns/1ps
module tb_func_sel_seq;

    localparam int FUNC_W    = 11;
    localparam int FUNC_ADD  = 0;
    localparam int FUNC_SUB  = 1;
    localparam int FUNC_MUL  = 24;
    localparam int MC_CYCLES = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        sel;
    logic [FUNC_W-1:0] func;
    logic              out_valid;
    logic              out_ready;
    logic [FUNC_W-1:0] out_func;
    logic              busy;
    logic [15:0]       perf_stall;

    int checks = 0;
    int errors = 0;

    func_sel_seq #(
        .FUNC_W(FUNC_W), .FUNC_ADD(FUNC_ADD), .FUNC_SUB(FUNC_SUB),
        .FUNC_MUL(FUNC_MUL), .MC_CYCLES(MC_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .func(func), .out_valid(out_valid), .out_ready(out_ready),
        .out_func(out_func), .busy(busy), .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FUNC_W-1:0] ref_code(input logic [1:0] s, input logic [FUNC_W-1:0] f);
        if (s == 2'd0) return f;
        if (s == 2'd3) return FUNC_W'(FUNC_SUB);
        return FUNC_W'(FUNC_ADD);
    endfunction

    // Reference model: the single output slot is empty, waiting, or ready
    logic [FUNC_W-1:0] sb_q[$];
    int  slot   = 0;          // 0 empty, 1 waiting, 2 ready
    int  wait_n = 0;
    int  m_perf = 0;
    bit  m_acc  = 0;

    always begin
        @(negedge clk);
        #0.5;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_out_func", out_func, 0);
            chk("rst_perf", perf_stall, 0);
            chk("rst_in_ready", in_ready, 1);
            slot = 0; wait_n = 0; m_perf = 0; m_acc = 0;
            sb_q.delete();
        end else begin
            bit exp_ready;
            exp_ready = (slot == 0) || (slot == 2 && out_ready);
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, slot == 2);
            chk("busy", busy, slot == 1);
            chk("perf_stall", perf_stall, m_perf);
            m_acc = in_valid && exp_ready;
            if (slot == 1) begin
`ifdef FUNC_SEL_PERF_EN
                if (m_perf < 16'hFFFF) m_perf++;
`endif
                wait_n--;
                if (wait_n == 0) slot = 2;
            end else if (slot == 2 && out_ready) begin
                slot = 0;
            end
            if (m_acc) begin
                int lat;
                sb_q.push_back(ref_code(sel, func));
                lat = (sel == 2'd0 && func == FUNC_W'(FUNC_MUL)) ? MC_CYCLES : 1;
                if (lat > 1) begin slot = 1; wait_n = lat - 1; end
                else slot = 2;
            end
        end
    end

    // Monitor: compare whatever the DUT presents against the queue head
    always begin
        @(negedge clk);
        if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                chk("out_func", out_func, sb_q[0]);
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    // Present one op and hold it until the model sees it accepted
    task automatic send(input logic [1:0] s, input logic [FUNC_W-1:0] f,
                        input int pct, input int hold);
        int  n;
        bit  done;
        n = 0; done = 0;
        in_valid = 1'b1; sel = s; func = f;
        while (!done) begin
            out_ready = (n < hold) ? 1'b0 : ($urandom_range(0, 99) < pct);
            @(negedge clk); #1;
            done = m_acc;
            n++;
            @(posedge clk); #1;
            if (!done && n > 200) begin
                chk("accept_timeout", 0, 1);
                done = 1;
            end
        end
        in_valid = 1'b0;
        sel  = 2'($urandom_range(0, 3));
        func = FUNC_W'($urandom);
    endtask

    task automatic idle(input int n, input int pct);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            out_ready = ($urandom_range(0, 99) < pct);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 2'd0; func = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Plain CALCU pass-through
        send(2'd0, FUNC_W'(11'h020), 100, 0);
        idle(2, 100);
        // LOAD/SAVE/BEQ back-to-back
        send(2'd1, FUNC_W'(11'h3A5), 100, 0);
        send(2'd2, FUNC_W'(11'h011), 100, 0);
        send(2'd3, FUNC_W'(11'h7FF), 100, 0);
        idle(2, 100);
        // Multi-cycle op followed by an op offered during BUSY
        send(2'd0, FUNC_W'(FUNC_MUL), 100, 0);
        send(2'd1, FUNC_W'(11'h123), 100, 0);
        idle(2, 100);
        // Output back-pressured five cycles with a pending input
        send(2'd0, FUNC_W'(11'h055), 100, 0);
        send(2'd3, FUNC_W'(11'h0AA), 100, 5);
        idle(2, 100);
        // Reset during BUSY, then a normal op
        send(2'd0, FUNC_W'(FUNC_MUL), 100, 0);
        idle(1, 100);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_out_valid", out_valid, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        send(2'd0, FUNC_W'(FUNC_MUL), 100, 0);
        idle(6, 100);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            logic [FUNC_W-1:0] f;
            f = ($urandom_range(0, 3) == 0) ? FUNC_W'(FUNC_MUL) : FUNC_W'($urandom);
            send(2'($urandom_range(0, 3)), f, 70, $urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 60);
        end

        idle(20, 100);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
